// File: rtl/mmio_switch_port_if.sv
// Bus-side signals of the memory-mapped switch input port.
// Signals: sel (access targets this port this cycle), we (write enable),
// addr (byte address, only [3:2] decoded), wdata (write data),
// rdata (registered read data).
interface mmio_switch_port_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  // Processor / data-memory bus side
  modport master (
    output sel,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  // Responder side
  modport slave (
    input  sel,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/mmio_switch_port.sv
// mmio_switch_port: memory-mapped input responder for the board switches.
// Each switch is synchronised (2 flops), debounced (DEBOUNCE_CYCLES stable
// cycles; 0 bypasses the filter), and its rising edges are latched in a
// sticky EDGE register that software clears with write-1-to-clear.
// Register map by addr[3:2]:
//   0 DATA   RO  debounced switch levels
//   1 EDGE   R/W1C sticky rising-edge flags
//   2 MASK   RW  interrupt mask (reads 0, writes ignored without IO_IRQ_EN)
//   3 STATUS RO  bit0 = any edge pending
// Optional feature macro: IO_IRQ_EN -- adds the MASK flops and a registered
// irq = |(edge & mask). Without it irq_o is tied low.
module mmio_switch_port #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NSW             = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NSW-1:0]      sw_i,
  mmio_switch_port_if.slave   bus,
  output logic                irq_o
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least 1 bit so
  // the declarations stay legal when the filter is bypassed.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_EDGE   = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [NSW-1:0] s1_q;
  logic [NSW-1:0] s2_q;
  logic [NSW-1:0] stable_q;
  logic [NSW-1:0] stable_d;
  logic [NSW-1:0] edge_q;
  logic [NSW-1:0] edge_d;
  logic [NSW-1:0] mask_q;
  logic [NSW-1:0] clr_bits;
  logic [31:0]    rdata_q;
  logic [31:0]    rdata_d;
  logic [31:0]    rd_word;
  logic [1:0]     reg_idx;
  logic           rd_en;
  logic           wr_en;

  // Only addr[3:2] and wdata[NSW-1:0] are decoded; fold the rest into a
  // sink so the unused bus bits are visibly intentional.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr, bus.wdata};

  assign reg_idx = bus.addr[3:2];
  assign rd_en   = bus.sel & ~bus.we;
  assign wr_en   = bus.sel & bus.we;

  // Two-flop synchroniser for the raw asynchronous switch levels
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce filter producing the next accepted level stable_d
  genvar gi;
  generate
    for (gi = 0; gi < NSW; gi++) begin : g_bit
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign stable_d[gi] = s2_q[gi];
      end else begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             flip;

        // Count consecutive cycles the synchronised level disagrees with
        // the accepted level; accept it on the DEBOUNCE_CYCLES-th one
        always_comb begin
          cnt_d = cnt_q + CNT_W'(1);
          flip  = 1'b0;
          if (s2_q[gi] == stable_q[gi]) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            flip  = 1'b1;
          end
        end

        assign stable_d[gi] = stable_q[gi] ^ flip;

        // Debounce counter register
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      end
    end
  endgenerate

  // W1C request from a bus write to EDGE; a rise in the same cycle wins
  always_comb begin
    clr_bits = '0;
    if (wr_en && (reg_idx == REG_EDGE)) begin
      clr_bits = bus.wdata[NSW-1:0];
    end
    edge_d = (edge_q & ~clr_bits) | (stable_d & ~stable_q);
  end

  // Accepted levels and sticky rising-edge flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= '0;
      edge_q   <= '0;
    end else begin
      stable_q <= stable_d;
      edge_q   <= edge_d;
    end
  end

  // Read multiplexer over the current register values (pre-update view)
  always_comb begin
    rd_word = '0;
    case (reg_idx)
      REG_DATA:   rd_word[NSW-1:0] = stable_q;
      REG_EDGE:   rd_word[NSW-1:0] = edge_q;
      REG_MASK:   rd_word[NSW-1:0] = mask_q;
      REG_STATUS: rd_word[0]       = |edge_q;
      default:    rd_word          = '0;
    endcase
    rdata_d = rd_en ? rd_word : rdata_q;
  end

  // Registered read data; holds its value when no read is issued
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;

`ifdef IO_IRQ_EN
  logic irq_q;

  // Interrupt mask register and registered interrupt request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && (reg_idx == REG_MASK)) begin
        mask_q <= bus.wdata[NSW-1:0];
      end
      irq_q <= |(edge_q & mask_q);
    end
  end

  assign irq_o = irq_q;
`else
  // No mask storage: MASK reads as zero and the interrupt is never raised
  assign mask_q = '0;
  assign irq_o  = 1'b0;
`endif

endmodule
